// File: rtl/uart_host_ctrl_pkg.sv
// Shared types and constants for the UART host-command sequencer.
//   host_op_t    : command opcode field (bits [7:6] of a command byte)
//   host_state_t : sequencer state encoding
//   host_cmd_t   : packed view of a command byte {op, rsv, addr}
//   REG_*        : register-file offsets
//   is_rd_addr_valid / is_wr_addr_valid : per-op address legality
package uart_host_ctrl_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned BURST_LEN = 3;

  localparam logic [ADDR_W-1:0] REG_CR    = 3'd0;
  localparam logic [ADDR_W-1:0] REG_SR    = 3'd1;
  localparam logic [ADDR_W-1:0] REG_DINL  = 3'd2;
  localparam logic [ADDR_W-1:0] REG_DINH  = 3'd3;
  localparam logic [ADDR_W-1:0] REG_DOUTL = 3'd4;
  localparam logic [ADDR_W-1:0] REG_DOUTM = 3'd5;
  localparam logic [ADDR_W-1:0] REG_DOUTH = 3'd6;

  typedef enum logic [1:0] {
    RD    = 2'b00,
    WR    = 2'b01,
    BURST = 2'b10,
    RSV   = 2'b11
  } host_op_t;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_DATA,
    RD_REQ,
    TX
  } host_state_t;

  typedef struct packed {
    host_op_t          op;
    logic [2:0]        rsv;
    logic [ADDR_W-1:0] addr;
  } host_cmd_t;

  // Registers the host may read individually.
  function automatic logic is_rd_addr_valid(input logic [ADDR_W-1:0] a);
    case (a)
      REG_CR, REG_SR, REG_DOUTL, REG_DOUTM, REG_DOUTH: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  // Registers the host may write.
  function automatic logic is_wr_addr_valid(input logic [ADDR_W-1:0] a);
    case (a)
      REG_CR, REG_DINL, REG_DINH: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_host_ctrl_if.sv
// Bus bundle between the host sequencer and its RX FIFO, TX FIFO and
// register file. Signal names follow the sequencer's point of view.
//   master : the sequencer (drives pops, pushes and register strobes)
//   slave  : the FIFOs / register file side
interface uart_host_ctrl_if;
  import uart_host_ctrl_pkg::*;

  logic [DATA_W-1:0] i_rx_data;
  logic              i_rx_empty;
  logic              o_rx_rd;
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_wr;
  logic              i_tx_full;
  logic [ADDR_W-1:0] o_rwaddr;
  logic [DATA_W-1:0] o_write_data;
  logic              o_wr_req;
  logic              o_rd_req;
  logic [DATA_W-1:0] i_read_data;

  modport master (
    input  i_rx_data, i_rx_empty, i_tx_full, i_read_data,
    output o_rx_rd, o_tx_data, o_tx_wr, o_rwaddr, o_write_data, o_wr_req, o_rd_req
  );

  modport slave (
    output i_rx_data, i_rx_empty, i_tx_full, i_read_data,
    input  o_rx_rd, o_tx_data, o_tx_wr, o_rwaddr, o_write_data, o_wr_req, o_rd_req
  );
endinterface

// File: rtl/uart_host_ctrl.sv
// Host-command sequencer: pops command bytes from the RX FIFO, performs
// single register reads/writes or a 3-byte DOUT burst read on the register
// file, and pushes read responses into the TX FIFO.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : FIFO + register-file bundle (master side)
//   o_busy       : high whenever the sequencer is not idle
//   o_err_cnt    : saturating count of protocol errors (bad cmd, timeout)
module uart_host_ctrl
  import uart_host_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  uart_host_ctrl_if.master   bus,
  output logic               o_busy,
  output logic [ERR_W-1:0]   o_err_cnt
);

  localparam int unsigned       TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam int unsigned       CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  host_state_t       state_q;
  host_cmd_t         cmd_q;
  logic [CNT_W-1:0]  n_q;        // bytes in this transaction (1 or 3)
  logic [CNT_W-1:0]  req_cnt_q;  // read requests issued so far
  logic [CNT_W-1:0]  idx_q;      // capture index in RD_REQ, send index in TX
  logic [ADDR_W-1:0] addr_q;     // base offset of the read
  logic              rd_pend_q;  // read data is on i_read_data this cycle
  logic [TMR_W-1:0]  timer_q;
  logic [DATA_W-1:0] rd_buf_q [BURST_LEN];
  logic [ERR_W-1:0]  err_cnt_q;
  logic [ERR_W-1:0]  err_cnt_d;

  logic [DATA_W-1:0] tx_data_q;
  logic              tx_wr_q;
  logic [ADDR_W-1:0] rwaddr_q;
  logic [DATA_W-1:0] write_data_q;
  logic              wr_req_q;
  logic              rd_req_q;

  logic pop_c;
  logic cmd_err_c;

  // Pop only when the sequencer is ready to consume a byte.
  assign pop_c       = ((state_q == IDLE) || (state_q == WAIT_DATA)) && !bus.i_rx_empty;
  assign bus.o_rx_rd = pop_c;

  // Saturating error increment.
  assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);

  // Command legality from the latched command byte.
  always_comb begin
    cmd_err_c = 1'b0;
    case (cmd_q.op)
      RD:      cmd_err_c = !is_rd_addr_valid(cmd_q.addr);
      WR:      cmd_err_c = !is_wr_addr_valid(cmd_q.addr);
      BURST:   cmd_err_c = 1'b0;
      default: cmd_err_c = 1'b1;
    endcase
    if (cmd_q.rsv != 3'b000) cmd_err_c = 1'b1;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      n_q          <= '0;
      req_cnt_q    <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      rd_pend_q    <= 1'b0;
      timer_q      <= '0;
      err_cnt_q    <= '0;
      tx_data_q    <= '0;
      tx_wr_q      <= 1'b0;
      rwaddr_q     <= '0;
      write_data_q <= '0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      for (int unsigned i = 0; i < BURST_LEN; i++) rd_buf_q[i] <= '0;
    end else begin
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      tx_wr_q   <= 1'b0;
      rd_pend_q <= rd_req_q;

      case (state_q)
        IDLE: begin
          if (pop_c) begin
            cmd_q   <= host_cmd_t'(bus.i_rx_data);
            state_q <= DECODE;
          end
        end

        // First read request is issued on the decode edge so a single read
        // reaches the TX FIFO four cycles after its command pop.
        DECODE: begin
          idx_q   <= '0;
          timer_q <= '0;
          if (cmd_err_c) begin
            err_cnt_q <= err_cnt_d;
            state_q   <= IDLE;
          end else begin
            case (cmd_q.op)
              WR: state_q <= WAIT_DATA;
              BURST: begin
                n_q       <= CNT_W'(BURST_LEN);
                addr_q    <= REG_DOUTL;
                rwaddr_q  <= REG_DOUTL;
                rd_req_q  <= 1'b1;
                req_cnt_q <= CNT_ONE;
                state_q   <= RD_REQ;
              end
              default: begin
                n_q       <= CNT_ONE;
                addr_q    <= cmd_q.addr;
                rwaddr_q  <= cmd_q.addr;
                rd_req_q  <= 1'b1;
                req_cnt_q <= CNT_ONE;
                state_q   <= RD_REQ;
              end
            endcase
          end
        end

        WAIT_DATA: begin
          if (pop_c) begin
            write_data_q <= bus.i_rx_data;
            rwaddr_q     <= cmd_q.addr;
            wr_req_q     <= 1'b1;
            state_q      <= IDLE;
          end else if (timer_q == TMR_LAST) begin
            err_cnt_q <= err_cnt_d;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        // Requests go out back-to-back; captures trail them by one cycle.
        RD_REQ: begin
          if (req_cnt_q < n_q) begin
            rd_req_q  <= 1'b1;
            rwaddr_q  <= addr_q + ADDR_W'(req_cnt_q);
            req_cnt_q <= req_cnt_q + CNT_ONE;
          end
          if (rd_pend_q) begin
            rd_buf_q[idx_q] <= bus.i_read_data;
            if (idx_q == n_q - CNT_ONE) begin
              idx_q   <= '0;
              state_q <= TX;
            end else begin
              idx_q <= idx_q + CNT_ONE;
            end
          end
        end

        TX: begin
          if (!bus.i_tx_full) begin
            tx_wr_q   <= 1'b1;
            tx_data_q <= rd_buf_q[idx_q];
            if (idx_q == n_q - CNT_ONE) state_q <= IDLE;
            else                        idx_q   <= idx_q + CNT_ONE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_wr      = tx_wr_q;
  assign bus.o_rwaddr     = rwaddr_q;
  assign bus.o_write_data = write_data_q;
  assign bus.o_wr_req     = wr_req_q;
  assign bus.o_rd_req     = rd_req_q;
  assign o_busy           = (state_q != IDLE);
  assign o_err_cnt        = err_cnt_q;

endmodule

// File: doc/uart_host_ctrl.md
Name: uart_host_ctrl

Overview:
- Host-command sequencer between the UART RX/TX FIFOs and the UART register file.
- Pops command bytes from the RX FIFO and decodes single-register read, single-register write and a 3-byte burst read of the R-peak sample number.
- Drives the register file's address, data and read/write request lines, and pushes response bytes into the TX FIFO.

Parameters:
- TIMEOUT_CYCLES, 1000000: maximum cycles to wait for a write's data byte before the command is aborted.
- ERR_W, 8: width of the saturating error counter.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_rx_data  in  8  RX FIFO head byte (first-word-fall-through, valid while !i_rx_empty)
- i_rx_empty  in  1  RX FIFO empty
- o_rx_rd  out  1  RX FIFO pop (combinational)
- o_tx_data  out  8  byte to TX FIFO
- o_tx_wr  out  1  TX FIFO push
- i_tx_full  in  1  TX FIFO full
- o_rwaddr  out  3  register offset
- o_write_data  out  8  register write data
- o_wr_req  out  1  register write strobe
- o_rd_req  out  1  register read strobe
- i_read_data  in  8  register read data, valid exactly 1 cycle after o_rd_req
- o_busy  out  1  state != IDLE
- o_err_cnt  out  ERR_W  saturating count of protocol errors

Behaviour:
- Reset (i_rst high at a clock edge): state=IDLE; all registered outputs, timer, buffers and o_err_cnt = 0.
  - Reset mid-operation aborts with no further FIFO or register access; bytes already pushed stay pushed.
- Register offsets: CR=0, SR=1, DINL=2, DINH=3, DOUTL=4, DOUTM=5, DOUTH=6; 7 is invalid.
- Command byte fields: op=[7:6], rsv=[5:3], addr=[2:0].
  - op 00: read. Valid addr in {CR, SR, DOUTL, DOUTM, DOUTH}.
  - op 01: write. Valid addr in {CR, DINL, DINH}; the next RX byte is the data.
  - op 10: burst read of DOUTL, DOUTM, DOUTH. addr is ignored.
  - op 11, rsv!=0, or an invalid addr for the op: error.
- Error handling: o_err_cnt++ (saturating at all-ones), return to IDLE, no response byte.
- o_rx_rd = 1 only in IDLE or WAIT_DATA while !i_rx_empty. The byte is latched on that same edge.
- All other outputs are registered. Strobes are 1-cycle pulses.
- States:
  - IDLE: on pop, latch cmd -> DECODE.
  - DECODE: valid write -> WAIT_DATA with timer=0. Valid read -> RD_REQ with n=1. Burst -> RD_REQ with n=3 and addr=DOUTL. Error -> IDLE.
  - WAIT_DATA: on pop, o_write_data=byte and o_wr_req=1 next cycle -> IDLE. Otherwise timer++. When timer==TIMEOUT_CYCLES-1 -> error.
  - RD_REQ: o_rd_req pulses on n consecutive cycles with o_rwaddr = addr, addr+1, addr+2. i_read_data is captured into buf[k] one cycle after each request. After the last capture -> TX, k=0.
  - TX: if !i_tx_full, o_tx_wr=1 and o_tx_data=buf[k], k++; when k reaches n -> IDLE. If i_tx_full, stall, holding o_tx_wr=0.
- Burst requests are back-to-back so the 3 bytes sample the register file within a 3-cycle window.
- Latency, single read from command pop to o_tx_wr with TX not full: 4 cycles (DECODE, RD_REQ, capture, TX).
- o_wr_req and o_rd_req are never asserted in the same cycle.
- A new command is not accepted until the previous one completes.

Decomposition:
- Add to uart_pkg:
  - host_op_t enum (RD, WR, BURST, RSV)
  - host_state_t enum (IDLE, DECODE, WAIT_DATA, RD_REQ, TX)
  - the register offset constants
  - BURST_LEN=3
  - function is_rd_addr_valid / is_wr_addr_valid
- Single module. The timeout counter is inline; no sub-module is warranted.

Test Plan:
- RX 0x40,0x05 (write CR=0x05) -> one o_wr_req cycle with o_rwaddr=0, o_write_data=0x05; no TX push; o_err_cnt=0.
- RX 0x01 (read SR), i_read_data=0xA3 one cycle after o_rd_req -> exactly one TX push of 0xA3, 4 cycles after the pop.
- RX 0x80, register returns 0x34,0x12,0x02 for offsets 4,5,6 -> o_rd_req on 3 consecutive cycles; TX pushes 0x34,0x12,0x02 in order. Hold i_tx_full for 5 cycles mid-burst -> no lost or duplicated bytes.
- RX 0x41 (write SR), 0xC0, 0x07, 0x08 -> o_err_cnt=4; no register strobes or TX pushes. Force o_err_cnt to 0xFF, send an error command -> stays 0xFF.
- TIMEOUT_CYCLES=16: RX 0x42, no data byte -> back to IDLE after 16 cycles in WAIT_DATA with o_err_cnt=1. A subsequent 0x00 read completes normally.
- Assert i_rst during burst TX after 1 byte -> next cycle all outputs 0, o_busy=0; no further pushes.
